// File: rtl/aes_pkg.sv
// Shared AES datapath constants, state typedefs and the SubBytes engine FSM encoding.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTE_W  = 8;
    localparam int unsigned AES_NBYTES  = 16;

    typedef logic [AES_BYTE_W-1:0]                  aes_byte_t;
    typedef logic [AES_NBYTES-1:0][AES_BYTE_W-1:0]  aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sb_state_t;

    // Lane counts must evenly tile the 16-byte state with a power-of-two group count.
    function automatic bit lanes_legal(input int unsigned lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/subbytes_iter_128_if.sv
// Valid/ready in/out channels of the iterative SubBytes engine.
interface subbytes_iter_128_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_data;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_data;
    logic       busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/SubBytes.sv
// Combinational forward AES S-box; table row-major from entry 0x00 at the MSB end.
module SubBytes (
    input  logic [7:0] matrix_in,
    output logic [7:0] matrix_out
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry k sits at bit offset (255-k)*8, and 255-k is the bitwise complement of k.
    logic [10:0] w_idx;
    assign w_idx      = {~matrix_in, 3'b000};
    assign matrix_out = SBOX[w_idx +: 8];

endmodule

// File: rtl/subbytes_iter_128.sv
// Iterative forward SubBytes: substitutes LANES bytes per cycle in place, lowest group first.
module subbytes_iter_128
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    subbytes_iter_128_if.slave bus
);

    localparam int unsigned NGRP  = AES_NBYTES / LANES;
    localparam int unsigned CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGRP - 1);

    if (!lanes_legal(LANES)) begin : g_lanes_chk
        $error("subbytes_iter_128: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_t              r_state;
    sb_state_t              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    aes_state_t             r_work;
    aes_state_t             w_work_nxt;
    logic [3:0]             w_base;
    aes_byte_t [LANES-1:0]  w_lane_in;
    aes_byte_t [LANES-1:0]  w_lane_out;

    assign w_base = 4'(32'(r_cnt) * LANES);

    // Lane-input mux: pick the current byte group out of the working register.
    always_comb begin
        w_lane_in = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            w_lane_in[l] = r_work[w_base + 4'(l)];
        end
    end

    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        SubBytes u_sbox (
            .matrix_in  (w_lane_in[l]),
            .matrix_out (w_lane_out[l])
        );
    end

    // Next-state, counter and write-back demux.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_work_nxt  = r_work;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_work_nxt  = bus.in_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < int'(LANES); l++) begin
                    w_work_nxt[w_base + 4'(l)] = w_lane_out[l];
                end
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        w_work_nxt  = bus.in_data;
                        w_cnt_nxt   = '0;
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_work  <= w_work_nxt;
        end
    end

    // In DONE a new state can only enter while the current result retires.
    assign bus.in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_data  = r_work;

endmodule

// File: tb/tb_subbytes_iter_128.sv
// Scoreboard bench for subbytes_iter_128; reference S-box built from GF(2^8) inverse + affine map.
module tb_subbytes_iter_128;
    import aes_pkg::*;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic clk = 1'b0;
    logic rst_n;
    logic aux_go;
    int   total = 0;
    int   bad   = 0;
    logic [127:0] sbq[$];

    always #5 clk = ~clk;

    subbytes_iter_128_if m_if ();
    subbytes_iter_128 #(.LANES(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m_if));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a, y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int y = 1; y < 256; y++) begin
            if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] sub_ref(input logic [127:0] st);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_ref(st[i*8 +: 8]);
        return r;
    endfunction

    // Retire monitor: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && m_if.out_valid && m_if.out_ready) begin
            logic [127:0] exp;
            exp = (sbq.size() != 0) ? sbq.pop_front() : 'x;
            check("sb_data", m_if.out_data, exp);
        end
    end

    // Drive a state and return just after the accepting edge.
    task automatic send(input logic [127:0] d);
        m_if.in_valid = 1'b1;
        m_if.in_data  = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_if.in_ready) break;
        end
        check("accept", 128'(m_if.in_ready), 128'd1);
        if (m_if.in_ready) sbq.push_back(sub_ref(d));
        @(posedge clk);
        #1;
        m_if.in_valid = 1'b0;
    endtask

    // Count edges from accept until out_valid is seen; ends on that negedge.
    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_if.out_valid) break;
            n++;
        end
    endtask

    task automatic run_const(input string tag, input logic [127:0] d, input logic [127:0] exp);
        int n;
        send(d);
        wait_valid(n);
        check({tag, "_lat"}, 128'(n), 128'd4);
        check(tag, m_if.out_data, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  128'(m_if.in_ready),  128'd1);
        check({tag, "_out_valid"}, 128'(m_if.out_valid), 128'd0);
        check({tag, "_busy"},      128'(m_if.busy),      128'd0);
        check({tag, "_out_data"},  m_if.out_data,        128'd0);
    endtask

    for (genvar g = 0; g < 4; g++) begin : gen_aux
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        subbytes_iter_128_if a_if ();
        subbytes_iter_128 #(.LANES(L)) u_dut (.clk(clk), .rst_n(rst_n), .bus(a_if));
        bit done = 1'b0;

        initial begin
            int n;
            a_if.in_valid  = 1'b0;
            a_if.in_data   = '0;
            a_if.out_ready = 1'b1;
            wait (aux_go === 1'b1);
            @(posedge clk);
            #1;
            a_if.in_valid = 1'b1;
            a_if.in_data  = FIPS_IN;
            @(negedge clk);
            check($sformatf("aux%0d_ready", L), 128'(a_if.in_ready), 128'd1);
            @(posedge clk);
            #1;
            a_if.in_valid = 1'b0;
            n = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (a_if.out_valid) break;
                n++;
            end
            check($sformatf("aux%0d_lat", L),  128'(n), 128'(16 / L));
            check($sformatf("aux%0d_fips", L), a_if.out_data, FIPS_OUT);
            check($sformatf("aux%0d_ref", L),  a_if.out_data, sub_ref(FIPS_IN));
            done = 1'b1;
        end
    end

    initial begin
        int n;
        logic [127:0] d, a, b;
        rst_n          = 1'b0;
        aux_go         = 1'b0;
        m_if.in_valid  = 1'b0;
        m_if.in_data   = '0;
        m_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rel");
        aux_go = 1'b1;
        @(posedge clk);
        #1;

        m_if.out_ready = 1'b1;
        run_const("zero",  128'h0,                {16{8'h63}});
        run_const("ones",  {16{8'hff}},           {16{8'h16}});
        run_const("fips",  FIPS_IN,               FIPS_OUT);
        run_const("mixed", {4{32'hff530100}},     {4{32'h16ed7c63}});

        // Backpressure: result must hold while a stray in_valid pulse is ignored.
        m_if.out_ready = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d);
        wait_valid(n);
        check("bp_lat", 128'(n), 128'd4);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            m_if.in_valid = (c == 3);
            m_if.in_data  = ~d;
            @(negedge clk);
            check("bp_valid", 128'(m_if.out_valid), 128'd1);
            check("bp_ready", 128'(m_if.in_ready),  128'd0);
            check("bp_data",  m_if.out_data,        sub_ref(d));
        end
        @(posedge clk);
        #1;
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_retired", 128'(m_if.out_valid), 128'd0);
        check("bp_idle",    128'(m_if.busy),      128'd0);
        @(posedge clk);
        #1;

        // Back-to-back: new accept on the same edge the previous result retires.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        send(a);
        wait_valid(n);
        check("b2b_lat_a", 128'(n), 128'd4);
        #1;
        m_if.in_valid = 1'b1;
        m_if.in_data  = b;
        #1;
        check("b2b_ready", 128'(m_if.in_ready), 128'd1);
        sbq.push_back(sub_ref(b));
        @(posedge clk);
        #1;
        m_if.in_valid = 1'b0;
        check("b2b_busy", 128'(m_if.busy), 128'd1);
        wait_valid(n);
        check("b2b_lat_b", 128'(n), 128'd4);
        @(posedge clk);
        #1;

        for (int k = 0; k < 200; k++) begin
            if (gen_aux[0].done && gen_aux[1].done && gen_aux[2].done && gen_aux[3].done) break;
            @(posedge clk);
            #1;
        end
        check("aux_done", 128'({gen_aux[3].done, gen_aux[2].done, gen_aux[1].done, gen_aux[0].done}),
              128'h0f);

        // Abort a transaction at cnt=2 and make sure nothing of it survives.
        send(FIPS_IN);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sbq.pop_back());
        #1;
        check_idle("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("midrel");
        @(posedge clk);
        #1;
        run_const("post_rst", FIPS_IN, FIPS_OUT);

        check("sb_left", 128'(sbq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/subbytes_iter_128.md
# subbytes_iter_128

Iterative forward AES SubBytes engine for the encryption datapath. It takes one 128-bit AES state per transaction and replaces every byte with its forward S-box value. The work is time-multiplexed over a parameterised number of S-box lanes to save area. Transactions use a valid/ready handshake on both sides, so the block sits between AddRoundKey and ShiftRows in a multi-cycle round controller. It is the encrypt-direction counterpart of the inverse SubBytes stage.

## Interface
Parameters:
- `LANES`, default 4: S-box instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.

Ports:
- `clk`, input, 1: single clock. All state is updated on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: `in_data` holds a state to substitute.
- `in_ready`, output, 1: block can accept a state this cycle.
- `in_data`, input, 128: input state. Byte i is `in_data[i*8 +: 8]`.
- `out_valid`, output, 1: `out_data` holds a completed result.
- `out_ready`, input, 1: downstream accepts the result.
- `out_data`, output, 128: result. Byte i = S(input byte i).
- `busy`, output, 1: high while in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`=1, capture `in_data` into the working register, clear the group counter `cnt`, and go to RUN.
- RUN:
  - Each cycle, the `LANES` S-boxes substitute bytes `cnt*LANES` … `cnt*LANES+LANES-1` of the working register in place.
  - `cnt` increments each cycle.
  - When `cnt` = 16/`LANES`−1, the last group is written and the FSM goes to DONE.
  - Groups are processed lowest bytes first.
- DONE:
  - `out_valid`=1; the working register is held stable.
  - When `out_ready`=1, go to IDLE, unless a new input is accepted in the same cycle.
- Simultaneous event: in DONE, `in_ready` = `out_ready`. If `out_valid`, `out_ready` and `in_valid` are all high, the result retires and the new state is captured in the same edge. The FSM goes directly to RUN with `cnt`=0.
- `out_data` is driven directly by the working register. It is meaningful only while `out_valid`=1, and shows partial substitution during RUN.
- `in_valid` during RUN is ignored, because `in_ready`=0. The upstream must hold its data until the handshake completes.
- `cnt` width is max(1, log2(16/`LANES`)) bits. With `LANES`=16, RUN lasts one cycle.
- Reset at any time, including mid-RUN or in DONE:
  - FSM goes to IDLE immediately and the in-flight state is discarded.
  - `out_data` and `cnt` are cleared to 0.
  - `out_valid`=0, `busy`=0, `in_ready`=1 once reset is released.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=128'h0.
- Latency: input accepted at edge N gives `out_valid`=1 after edge N+16/`LANES`.
  - `LANES`=4: 4 cycles.
  - `LANES`=1: 16 cycles.
  - `LANES`=16: 1 cycle.
- Throughput with `out_ready` held at 1: one state per 16/`LANES`+1 cycles (RUN plus one DONE cycle that overlaps the next accept).
- The output handshake completes on any edge where `out_valid` and `out_ready` are both 1.
- `out_data` is stable from `out_valid` rising until that edge.
- `in_ready` and `out_valid` are decoded from the registered FSM state (and, for `in_ready`, from `out_ready`). There is no combinational path from `in_data` to any output.

## Structure
- Shared package `aes_pkg`:
  - `AES_STATE_W`=128, `AES_BYTE_W`=8, `AES_NBYTES`=16.
  - FSM enum `sb_state_t` {IDLE, RUN, DONE}.
  - A helper function that checks the legality of `LANES`.
- Sub-module `SubBytes`: combinational forward S-box, ports `matrix_in[7:0]` and `matrix_out[7:0]`. It is instantiated `LANES` times in a generate loop.
- The lane-input mux (select bytes by `cnt`) and the write-back demux are in the top module.

## Test plan
- Single byte values, `LANES`=4, `out_ready`=1:
  - `in_data`=128'h0 → `out_data`=128'h6363…63 (all 16 bytes 0x63), `out_valid` exactly 4 cycles after accept.
  - `in_data`=128'hff…ff → all bytes 0x16.
- FIPS-197 round-1 vector, run for every legal `LANES`:
  - `in_data`=128'h193de3bea0f4e22b9ac68d2ae9f84808 → `out_data`=128'hd42711aee0bf98f1b8b45de51e415230.
  - Latency must be 16/`LANES` cycles.
- Mixed bytes: `in_data` bytes 0x00, 0x01, 0x53, 0xff repeated → 0x63, 0x7c, 0xed, 0x16 in the same positions.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `out_data` stays stable, `in_ready`=0, and a pulsed `in_valid` is ignored.
  - Raising `out_ready` retires the result in one cycle.
- Back-to-back:
  - Raise `in_valid` in the DONE cycle with `out_ready`=1. Both handshakes complete on the same edge, the second result appears 4 cycles later, and no cycle is lost.
- Reset mid-RUN: assert `rst_n`=0 at `cnt`=2.
  - `out_valid`=0, `out_data`=0 and `in_ready`=1 immediately on release.
  - A new transaction then completes correctly with no residue from the aborted state.
